// File: rtl/arb_4req_priority_rr.sv
// rtl/arb_4req_priority_rr.sv - 4-requester fixed/round-robin arbiter with hold limit and release cycle
module arb_4req_priority_rr #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_v,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic             gnt_v_q, gnt_v_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       last_id_q, last_id_d;

    logic [1:0]       win_id;
    logic [1:0]       rr_idx;

    // Candidates are scanned from lowest to highest precedence so the last hit wins.
    always_comb begin
        win_id = 2'd0;
        rr_idx = 2'd0;
        if (!mode) begin
            for (int i = 3; i >= 0; i--) begin
                if (req[i]) win_id = 2'(i);
            end
        end else begin
            for (int k = 3; k >= 0; k--) begin
                rr_idx = last_id_q + 2'(k) + 2'd1;
                if (req[rr_idx]) win_id = rr_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        gnt_v_d    = gnt_v_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        last_id_d  = last_id_q;
        case (state_q)
            S_IDLE: begin
                if (req != 4'b0000) begin
                    gnt_d      = 4'b0001 << win_id;
                    gnt_id_d   = win_id;
                    gnt_v_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req[gnt_id_q] || hold_cnt_q == HOLD_LAST) begin
                    gnt_d     = 4'b0000;
                    gnt_v_d   = 1'b0;
                    last_id_d = gnt_id_q;
                    timeout_d = req[gnt_id_q];
                    state_d   = S_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 4'b0000;
                gnt_v_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= 4'b0000;
            gnt_id_q   <= 2'b00;
            gnt_v_q    <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_id_q  <= 2'b11;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_v_q    <= gnt_v_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            last_id_q  <= last_id_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_v   = gnt_v_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arb_4req_priority_rr.sv
// tb/tb_arb_4req_priority_rr.sv - scoreboard bench for arb_4req_priority_rr
module tb_arb_4req_priority_rr;

    localparam int MH = 8;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       mode = 1'b0;
    logic [3:0] req  = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_v;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int npops    = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       v;
        logic       to;
    } exp_t;

    exp_t sb[$];

    arb_4req_priority_rr #(.MAX_HOLD(MH), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_v   (gnt_v),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle 1=owning 2=dead cycle; held counts cycles of ownership.
    int m_phase, m_owner, m_held, m_last;
    bit m_to;

    function automatic int pick(input logic [3:0] r, input logic md, input int last);
        if (!md) begin
            for (int i = 0; i < 4; i++) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_phase = 0; m_owner = 0; m_held = 0; m_last = 3; m_to = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_to = 0;
                    if (req != 4'b0000) begin
                        m_owner = pick(req, mode, m_last);
                        m_held  = 1;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (!req[m_owner]) begin
                        m_last = m_owner; m_phase = 2; m_to = 0;
                    end else if (m_held == MH) begin
                        m_last = m_owner; m_phase = 2; m_to = 1;
                    end else begin
                        m_held++;
                    end
                end
                default: begin
                    m_phase = 0; m_to = 0;
                end
            endcase
        end
        e.v   = (m_phase == 1);
        e.gnt = e.v ? 4'(1 << m_owner) : 4'b0000;
        e.id  = 2'(m_owner);
        e.to  = m_to;
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            npops++;
            chk("sb_gnt", 32'(gnt), 32'(e.gnt));
            chk("sb_gnt_id", 32'(gnt_id), 32'(e.id));
            chk("sb_gnt_v", 32'(gnt_v), 32'(e.v));
            chk("sb_timeout", 32'(timeout), 32'(e.to));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        req = 4'b0000;
        repeat (4) cyc();
    endtask

    // Asynchronous reset pulse away from the clock edge; the pending expectation is stale.
    task automatic reset_mid();
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("rst_async_gnt", 32'(gnt), 32'h0);
        chk("rst_async_gnt_v", 32'(gnt_v), 32'h0);
        chk("rst_async_timeout", 32'(timeout), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int hi, to_at, regr, cnt, zero;
        int order[$];
        int gaps[$];
        int exp_order[5];

        repeat (2) cyc();
        rst = 1'b0;

        req = 4'b1111; mode = 1'b1;
        repeat (3) cyc();
        reset_mid();
        cyc();
        chk("rst_first_gnt", 32'(gnt), 32'h1);
        chk("rst_first_id", 32'(gnt_id), 32'h0);

        go_idle();
        mode = 1'b0; req = 4'b1110;
        cyc();
        chk("fix_gnt", 32'(gnt), 32'h2);
        chk("fix_id", 32'(gnt_id), 32'h1);
        req = 4'b1100;
        cyc();
        chk("fix_release", 32'(gnt_v), 32'h0);
        cyc();
        chk("fix_idle", 32'(gnt_v), 32'h0);
        cyc();
        chk("fix_next_gnt", 32'(gnt), 32'h4);
        chk("fix_next_id", 32'(gnt_id), 32'h2);

        go_idle();
        mode = 1'b0; req = 4'b0001;
        hi = 0; to_at = -1; regr = -1;
        for (int c = 1; c <= 14; c++) begin
            cyc();
            if (gnt_v && to_at < 0) hi++;
            if (timeout && to_at < 0) begin
                to_at = c;
                chk("to_gnt_zero", 32'(gnt), 32'h0);
            end
            if (gnt_v && to_at > 0 && regr < 0) regr = c;
        end
        chk("to_hold_len", 32'(hi), 32'(MH));
        chk("to_pulse_cycle", 32'(to_at), 32'(MH + 1));
        chk("to_regrant_cycle", 32'(regr), 32'(MH + 3));

        go_idle();
        reset_mid();
        mode = 1'b1; req = 4'b1111;
        cnt = 0; zero = 0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            cyc();
            if (gnt_v) begin
                if (cnt == 0) begin
                    order.push_back(int'(gnt_id));
                    if (order.size() > 1) gaps.push_back(zero);
                end
                cnt++;
                zero = 0;
                if (cnt == 2) req = req & ~gnt;
            end else begin
                cnt = 0;
                zero++;
                req = 4'b1111;
            end
        end
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
        foreach (gaps[i]) chk("rr_gap", 32'(gaps[i]), 32'd2);

        go_idle();
        mode = 1'b1; req = 4'b1101;
        cyc();
        chk("mc_gnt", 32'(gnt), 32'h4);
        mode = 1'b0;
        cyc();
        chk("mc_hold1", 32'(gnt), 32'h4);
        cyc();
        chk("mc_hold2", 32'(gnt), 32'h4);
        req = 4'b1001;
        cyc();
        chk("mc_release", 32'(gnt_v), 32'h0);
        repeat (2) cyc();
        chk("mc_fixed_next", 32'(gnt), 32'h1);

        go_idle();
        mode = 1'b0; req = 4'b1000;
        cyc();
        chk("rmg_gnt", 32'(gnt), 32'h8);
        repeat (4) cyc();
        mode = 1'b1; req = 4'b1010;
        reset_mid();
        cyc();
        chk("rmg_rr_gnt", 32'(gnt), 32'h2);
        chk("rmg_rr_id", 32'(gnt_id), 32'h1);

        for (int c = 0; c < 800; c++) begin
            cyc();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
            if ($urandom_range(0, 149) == 0) reset_mid();
        end

        go_idle();
        chk("sb_activity", 32'(npops > 800), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_4req_priority_rr.md
Name: arb_4req_priority_rr

Overview:
- 4-requester arbiter that shares one downstream resource; requester index 0 has the highest priority in fixed mode, the same priority order as the team's 4x2 priority encoder.
- Selects fixed-priority or round-robin arbitration and holds the grant while the winner keeps requesting.
- Bounds ownership with a hold-limit timeout, then inserts one dead cycle before re-arbitrating.
- Sits between the request sources and the shared-resource mux; gnt_id drives the mux select.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles gnt_v may stay high for one grant (legal range 1..2**CNT_W-1).
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = fixed priority (req[0] highest), 1 = round-robin
- req  input  4  request lines, level-sensitive, one per requester
- gnt  output  4  one-hot grant; all zero when no grant
- gnt_id  output  2  binary index of the granted requester; valid only when gnt_v=1
- gnt_v  output  1  grant valid, equals OR of gnt
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit

Behaviour:
- Reset values: gnt=4'b0000, gnt_id=2'b00, gnt_v=0, timeout=0, state=IDLE, hold_cnt=0, last_id=2'b11 (so the first round-robin search starts at index 0). Reset may assert mid-grant; all outputs clear asynchronously with no dead cycle.
- All outputs are registered.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0, select a winner combinationally, register gnt/gnt_id/gnt_v=1, clear hold_cnt, and go to GRANT.
  - Latency: req seen in IDLE at edge N gives gnt high after edge N (visible in cycle N+1).
  - If req == 0, stay in IDLE.
- Winner selection:
  - mode=0: lowest set index wins.
  - mode=1: search starts at (last_id+1) mod 4, ascending with wrap; first set bit wins.
  - mode is sampled only in IDLE; changes during GRANT or RELEASE have no effect on the current grant.
- GRANT:
  - Each cycle with req[gnt_id]=1 and hold_cnt < MAX_HOLD-1: hold_cnt increments and the grant holds.
  - req[gnt_id]=0: next edge clears gnt/gnt_v, sets last_id=gnt_id, goes to RELEASE, timeout stays 0.
  - req[gnt_id]=1 and hold_cnt == MAX_HOLD-1: next edge clears the grant, sets last_id=gnt_id, pulses timeout=1 for one cycle, goes to RELEASE.
  - Requests from other requesters are ignored during GRANT (no preemption).
- RELEASE: exactly one cycle with gnt=0 and gnt_v=0, then unconditionally IDLE. Request sources use this dead cycle for mux turnaround.
- Grant duration: the gnt_v high time is at most MAX_HOLD cycles per grant.
- Back-to-back minimum spacing: grant, one RELEASE cycle, one IDLE cycle, next grant. This gives 2 idle cycles between grants.
- In fixed mode a timed-out requester that keeps req high is re-granted if it is still the highest priority. This is intended; the timeout pulse lets software observe it.
- gnt_id holds its last value when gnt_v=0. Consumers must qualify gnt_id with gnt_v.
- MAX_HOLD=1: every grant lasts exactly 1 cycle and times out if req is still high.

Test Plan:
- Reset: assert rst mid-cycle with req=4'b1111 -> gnt=0000, gnt_v=0, timeout=0 immediately; after release with mode=1, the first grant is gnt=0001, gnt_id=00.
- Fixed priority: mode=0, req=4'b1110 in IDLE -> next cycle gnt=0010, gnt_id=01. Drop req[1] -> one RELEASE cycle, then gnt=0100, gnt_id=10.
- Round-robin fairness: mode=1, each requester raises req for 2 cycles then drops it, re-raising all 4 while waiting -> grant order 0,1,2,3,0, with exactly 2 zero-grant cycles between grants.
- Hold timeout: MAX_HOLD=8, mode=0, req=4'b0001 held constant -> gnt_v high exactly 8 cycles, timeout pulses 1 cycle with gnt=0, then re-grant of 0001 two cycles later.
- Mode change mid-grant: grant to 2 under mode=1, toggle mode to 0 during GRANT with req=4'b1101 -> current grant unaffected. After release, the next grant is 0001 (fixed mode applied in IDLE).
- Reset mid-grant: rst pulse while gnt=1000 and hold_cnt=5 -> outputs clear asynchronously, last_id returns to 11, and the next round-robin grant starts searching at index 0.
